// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//
// Shared encodings and constants for the unified-memory port arbiter.
//   arb_state_e : arbiter FSM states (ARB_IDLE, ARB_WAIT)
//   arb_owner_e : which requester owns the in-flight access (OWN_IF, OWN_MEM)
//   LAT_MIN/MAX : legal range of the RAM read latency parameter
//   CNT_W       : width of the latency down-counter, wide enough for LAT_MAX
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_WAIT = 1'b1
   } arb_state_e;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } arb_owner_e;

   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 4;
   localparam int CNT_W   = 3;

endpackage

// File: rtl/arb_latency_cnt.sv
// ---------------------------------------------------------------------------
// arb_latency_cnt
//
// Loadable down-counter that times one RAM access. It is loaded with the
// read latency when an access is granted and decrements every cycle after
// that, stopping at zero. 'done' marks the final cycle of the access (count
// equal to 1).
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset
//   load     in   load load_val this cycle (takes priority over decrement)
//   load_val in   CNT_W value to load
//   done     out  count_q == 1
// ---------------------------------------------------------------------------
module arb_latency_cnt
   import mem_port_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous RAM between the instruction-fetch
// requester (IF) and the load/store requester (MEM). One access is in flight
// at a time; each lasts LAT cycles, and a new grant may issue in the
// completion cycle of the previous one. MEM normally wins, but after
// MAX_STREAK consecutive contested MEM grants the next contested grant goes
// to IF. A fetch flushed while in flight still runs on the RAM but its
// if_rvalid is suppressed.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   if_req/if_addr/if_flush        fetch request, byte address, discard
//   if_gnt/if_rvalid/if_rdata      fetch accept, data valid, data
//   if_stall                       PC hold: if_req & ~if_rvalid
//   mem_req/mem_we/mem_addr/
//   mem_wdata                      load/store request
//   mem_gnt/mem_rvalid/mem_rdata   data accept, load data / store ack
//   ram_en/ram_we/ram_addr/
//   ram_wdata/ram_rdata            RAM macro port (rdata valid LAT after en)
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int LAT        = 2,
   parameter int MAX_STREAK = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   input  logic              if_flush,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   output logic              if_stall,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic              mem_gnt,
   output logic              mem_rvalid,
   output logic [31:0]       mem_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   localparam int STREAK_W = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
   localparam logic [CNT_W-1:0]    LAT_LOAD   = CNT_W'(LAT);

   generate
      if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_lat_range_check
         $error("mem_port_arbiter: LAT must be within %0d..%0d", LAT_MIN, LAT_MAX);
      end
   endgenerate

   arb_state_e          state_q;
   arb_state_e          state_d;
   arb_owner_e          owner_q;
   arb_owner_e          owner_d;
   logic                store_q;
   logic                store_d;
   logic                drop_q;
   logic                drop_d;
   logic [STREAK_W-1:0] streak_q;
   logic [STREAK_W-1:0] streak_d;

   logic cnt_done;
   logic complete;
   logic can_grant;
   logic if_eligible;
   logic if_forced;
   logic grant_if;
   logic grant_mem;
   logic grant_any;

   // Only the RAM word-address bits are used from either byte address.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                               mem_addr[31:ADDR_W+2], mem_addr[1:0]};

   // A request still high in the completion cycle is treated as the
   // requester's next access, which gives back-to-back throughput.
   // Grants are masked while rst is high so every output reads 0 in reset.
   assign complete    = (state_q == ARB_WAIT) && cnt_done;
   assign can_grant   = !rst && ((state_q == ARB_IDLE) || complete);
   assign if_eligible = if_req && !if_flush;
   assign if_forced   = if_eligible && (streak_q == STREAK_MAX);
   assign grant_mem   = can_grant && mem_req && !if_forced;
   assign grant_if    = can_grant && if_eligible && !grant_mem;
   assign grant_any   = grant_if || grant_mem;

   arb_latency_cnt u_lat_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (grant_any),
      .load_val (LAT_LOAD),
      .done     (cnt_done)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ARB_IDLE;
         owner_q  <= OWN_IF;
         store_q  <= 1'b0;
         drop_q   <= 1'b0;
         streak_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         store_q  <= store_d;
         drop_q   <= drop_d;
         streak_q <= streak_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      store_d  = store_q;
      drop_d   = drop_q;
      streak_d = streak_q;

      if (grant_any) begin
         state_d = ARB_WAIT;
      end else if (complete) begin
         state_d = ARB_IDLE;
      end

      if (grant_mem) begin
         owner_d = OWN_MEM;
         store_d = mem_we;
      end else if (grant_if) begin
         owner_d = OWN_IF;
         store_d = 1'b0;
      end

      // drop only ever marks an in-flight fetch; any access boundary clears it.
      if (grant_any || complete) begin
         drop_d = 1'b0;
      end else if ((state_q == ARB_WAIT) && (owner_q == OWN_IF) && if_flush) begin
         drop_d = 1'b1;
      end

      // Counts MEM grants that beat a waiting fetch; saturates at the limit.
      if (!if_req || grant_if) begin
         streak_d = '0;
      end else if (grant_mem && (streak_q != STREAK_MAX)) begin
         streak_d = streak_q + STREAK_W'(1);
      end
   end

   // Output logic.
   always_comb begin
      if_gnt    = grant_if;
      mem_gnt   = grant_mem;
      ram_en    = grant_any;
      ram_we    = grant_mem && mem_we;
      ram_addr  = '0;
      ram_wdata = '0;
      if (grant_mem) begin
         ram_addr = mem_addr[ADDR_W+1:2];
         if (mem_we) begin
            ram_wdata = mem_wdata;
         end
      end else if (grant_if) begin
         ram_addr = if_addr[ADDR_W+1:2];
      end

      // A flush arriving in the completion cycle also discards that fetch.
      if_rvalid  = complete && (owner_q == OWN_IF) && !drop_q && !if_flush;
      mem_rvalid = complete && (owner_q == OWN_MEM);
      if_rdata   = if_rvalid ? ram_rdata : '0;
      mem_rdata  = (mem_rvalid && !store_q) ? ram_rdata : '0;
      if_stall   = !rst && if_req && !if_rvalid;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with LAT=2, MAX_STREAK=3, ADDR_W=10.
// A behavioural RAM returns word i as 32'hC0DE_0000 + i two cycles after
// ram_en, and returns 32'hBAD0_BAD0 when no read was issued so stray rdata
// is visible. Inputs are driven on the falling edge; outputs are sampled
// 1 time unit later.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int ADDR_W     = 10;
   localparam int LAT        = 2;
   localparam int MAX_STREAK = 3;

   logic              clk;
   logic              rst;
   logic              if_req;
   logic [31:0]       if_addr;
   logic              if_flush;
   logic              if_gnt;
   logic              if_rvalid;
   logic [31:0]       if_rdata;
   logic              if_stall;
   logic              mem_req;
   logic              mem_we;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [112:0] all_out;
   assign all_out = {if_gnt, if_rvalid, if_rdata, if_stall, mem_gnt, mem_rvalid,
                     mem_rdata, ram_en, ram_we, ram_addr, ram_wdata};

   mem_port_arbiter #(
      .ADDR_W     (ADDR_W),
      .LAT        (LAT),
      .MAX_STREAK (MAX_STREAK)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_flush   (if_flush),
      .if_gnt     (if_gnt),
      .if_rvalid  (if_rvalid),
      .if_rdata   (if_rdata),
      .if_stall   (if_stall),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Two-stage read pipeline RAM model (LAT = 2).
   logic [31:0] ram_mem [0:1023];
   logic [31:0] pipe1;
   logic [31:0] pipe2;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         ram_mem[i] = 32'hC0DE_0000 + i;
      end
      pipe1 = 32'hBAD0_BAD0;
      pipe2 = 32'hBAD0_BAD0;
   end

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
         end
         pipe1 <= ram_mem[ram_addr];
      end else begin
         pipe1 <= 32'hBAD0_BAD0;
      end
      pipe2 <= pipe1;
   end

   assign ram_rdata = pipe2;

   task automatic test_reset;
      @(negedge clk); #1;
      vec_cnt++; if (all_out !== '0) begin err_cnt++; $display("[TB] FAIL reset_idle outputs got %h exp 0", all_out); end
      @(negedge clk); if_req = 1'b1; if_addr = 32'h40; mem_req = 1'b1; mem_addr = 32'h100; #1;
      vec_cnt++; if (all_out !== '0) begin err_cnt++; $display("[TB] FAIL reset_req_held outputs got %h exp 0", all_out); end
      @(negedge clk); if_req = 1'b0; mem_req = 1'b0; rst = 1'b0; #1;
      vec_cnt++; if (all_out !== '0) begin err_cnt++; $display("[TB] FAIL reset_release outputs got %h exp 0", all_out); end
   endtask

   task automatic test_back_to_back;
      // t: fetch 0x40
      @(negedge clk); if_req = 1'b1; if_addr = 32'h40; #1;
      vec_cnt++; if (if_gnt !== 1'b1) begin err_cnt++; $display("[TB] FAIL b2b_t0_if_gnt got %b exp 1", if_gnt); end
      vec_cnt++; if (ram_addr !== 10'h010) begin err_cnt++; $display("[TB] FAIL b2b_t0_ram_addr got %h exp 010", ram_addr); end
      vec_cnt++; if ({ram_en, ram_we, mem_gnt} !== 3'b100) begin err_cnt++; $display("[TB] FAIL b2b_t0_en_we_mgnt got %b exp 100", {ram_en, ram_we, mem_gnt}); end
      vec_cnt++; if (if_stall !== 1'b1) begin err_cnt++; $display("[TB] FAIL b2b_t0_stall got %b exp 1", if_stall); end
      // t+1
      @(negedge clk); #1;
      vec_cnt++; if ({if_gnt, if_rvalid, ram_en, if_stall} !== 4'b0001) begin err_cnt++; $display("[TB] FAIL b2b_t1 gnt/rvalid/en/stall got %b exp 0001", {if_gnt, if_rvalid, ram_en, if_stall}); end
      vec_cnt++; if (if_rdata !== 32'h0) begin err_cnt++; $display("[TB] FAIL b2b_t1_rdata got %h exp 0", if_rdata); end
      // t+2: completion, next fetch 0x44 granted in the same cycle
      @(negedge clk); if_addr = 32'h44; #1;
      vec_cnt++; if (if_rvalid !== 1'b1) begin err_cnt++; $display("[TB] FAIL b2b_t2_rvalid got %b exp 1", if_rvalid); end
      vec_cnt++; if (if_rdata !== 32'hC0DE_0010) begin err_cnt++; $display("[TB] FAIL b2b_t2_rdata got %h exp c0de0010", if_rdata); end
      vec_cnt++; if (if_stall !== 1'b0) begin err_cnt++; $display("[TB] FAIL b2b_t2_stall got %b exp 0", if_stall); end
      vec_cnt++; if (if_gnt !== 1'b1) begin err_cnt++; $display("[TB] FAIL b2b_t2_if_gnt got %b exp 1", if_gnt); end
      vec_cnt++; if (ram_addr !== 10'h011) begin err_cnt++; $display("[TB] FAIL b2b_t2_ram_addr got %h exp 011", ram_addr); end
      // t+3
      @(negedge clk); #1;
      vec_cnt++; if ({if_rvalid, if_stall} !== 2'b01) begin err_cnt++; $display("[TB] FAIL b2b_t3 rvalid/stall got %b exp 01", {if_rvalid, if_stall}); end
      // t+4
      @(negedge clk); if_req = 1'b0; #1;
      vec_cnt++; if (if_rvalid !== 1'b1) begin err_cnt++; $display("[TB] FAIL b2b_t4_rvalid got %b exp 1", if_rvalid); end
      vec_cnt++; if (if_rdata !== 32'hC0DE_0011) begin err_cnt++; $display("[TB] FAIL b2b_t4_rdata got %h exp c0de0011", if_rdata); end
      vec_cnt++; if ({if_gnt, mem_rvalid} !== 2'b00) begin err_cnt++; $display("[TB] FAIL b2b_t4 gnt/mrvalid got %b exp 00", {if_gnt, mem_rvalid}); end
      // idle
      @(negedge clk); #1;
      vec_cnt++; if (all_out !== '0) begin err_cnt++; $display("[TB] FAIL b2b_idle outputs got %h exp 0", all_out); end
   endtask

   task automatic test_contention;
      @(negedge clk); if_req = 1'b1; if_addr = 32'h48; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; #1;
      vec_cnt++; if ({mem_gnt, if_gnt} !== 2'b10) begin err_cnt++; $display("[TB] FAIL cont_t0 mgnt/ignt got %b exp 10", {mem_gnt, if_gnt}); end
      vec_cnt++; if (ram_addr !== 10'h040) begin err_cnt++; $display("[TB] FAIL cont_t0_ram_addr got %h exp 040", ram_addr); end
      vec_cnt++; if (if_stall !== 1'b1) begin err_cnt++; $display("[TB] FAIL cont_t0_stall got %b exp 1", if_stall); end
      @(negedge clk); #1;
      vec_cnt++; if ({mem_gnt, if_gnt, mem_rvalid} !== 3'b000) begin err_cnt++; $display("[TB] FAIL cont_t1 mgnt/ignt/mrvalid got %b exp 000", {mem_gnt, if_gnt, mem_rvalid}); end
      @(negedge clk); mem_req = 1'b0; #1;
      vec_cnt++; if (mem_rvalid !== 1'b1) begin err_cnt++; $display("[TB] FAIL cont_t2_mrvalid got %b exp 1", mem_rvalid); end
      vec_cnt++; if (mem_rdata !== 32'hC0DE_0040) begin err_cnt++; $display("[TB] FAIL cont_t2_mrdata got %h exp c0de0040", mem_rdata); end
      vec_cnt++; if ({if_gnt, mem_gnt, if_rvalid} !== 3'b100) begin err_cnt++; $display("[TB] FAIL cont_t2 ignt/mgnt/irvalid got %b exp 100", {if_gnt, mem_gnt, if_rvalid}); end
      vec_cnt++; if (ram_addr !== 10'h012) begin err_cnt++; $display("[TB] FAIL cont_t2_ram_addr got %h exp 012", ram_addr); end
      @(negedge clk); #1;
      @(negedge clk); if_req = 1'b0; #1;
      vec_cnt++; if ({if_rvalid, mem_rvalid} !== 2'b10) begin err_cnt++; $display("[TB] FAIL cont_t4 irvalid/mrvalid got %b exp 10", {if_rvalid, mem_rvalid}); end
      vec_cnt++; if (if_rdata !== 32'hC0DE_0012) begin err_cnt++; $display("[TB] FAIL cont_t4_rdata got %h exp c0de0012", if_rdata); end
   endtask

   task automatic test_streak;
      // Grants land on even cycles: MEM, MEM, MEM, IF, MEM.
      logic [9:0] exp_m;
      logic [9:0] exp_i;
      exp_m = 10'b01_0001_0101;
      exp_i = 10'b00_0100_0000;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); if_req = 1'b1; if_addr = 32'h40; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; #1;
         vec_cnt++; if (mem_gnt !== exp_m[i]) begin err_cnt++; $display("[TB] FAIL streak_c%0d_mem_gnt got %b exp %b", i, mem_gnt, exp_m[i]); end
         vec_cnt++; if (if_gnt !== exp_i[i]) begin err_cnt++; $display("[TB] FAIL streak_c%0d_if_gnt got %b exp %b", i, if_gnt, exp_i[i]); end
         if (i == 7) begin
            vec_cnt++; if (dut.streak_q !== '0) begin err_cnt++; $display("[TB] FAIL streak_clear got %0d exp 0", dut.streak_q); end
         end
         if (i == 8) begin
            vec_cnt++; if ({if_rvalid, if_rdata} !== {1'b1, 32'hC0DE_0010}) begin err_cnt++; $display("[TB] FAIL streak_c8_if_data got %b/%h exp 1/c0de0010", if_rvalid, if_rdata); end
         end
      end
      @(negedge clk); if_req = 1'b0; mem_req = 1'b0; #1;
      vec_cnt++; if ({mem_rvalid, mem_rdata} !== {1'b1, 32'hC0DE_0040}) begin err_cnt++; $display("[TB] FAIL streak_end_mem got %b/%h exp 1/c0de0040", mem_rvalid, mem_rdata); end
      vec_cnt++; if ({if_gnt, mem_gnt} !== 2'b00) begin err_cnt++; $display("[TB] FAIL streak_end_gnts got %b exp 00", {if_gnt, mem_gnt}); end
   endtask

   task automatic test_flush;
      @(negedge clk); if_req = 1'b1; if_addr = 32'h4C; #1;
      vec_cnt++; if ({if_gnt, ram_addr} !== {1'b1, 10'h013}) begin err_cnt++; $display("[TB] FAIL flush_t0 gnt/addr got %b/%h exp 1/013", if_gnt, ram_addr); end
      @(negedge clk); if_req = 1'b0; if_flush = 1'b1; #1;
      vec_cnt++; if ({if_gnt, if_rvalid} !== 2'b00) begin err_cnt++; $display("[TB] FAIL flush_t1 gnt/rvalid got %b exp 00", {if_gnt, if_rvalid}); end
      @(negedge clk); if_flush = 1'b0; if_req = 1'b1; if_addr = 32'h50; #1;
      vec_cnt++; if (if_rvalid !== 1'b0) begin err_cnt++; $display("[TB] FAIL flush_t2_dropped_rvalid got %b exp 0", if_rvalid); end
      vec_cnt++; if ({if_gnt, ram_addr, if_stall} !== {1'b1, 10'h014, 1'b1}) begin err_cnt++; $display("[TB] FAIL flush_t2 gnt/addr/stall got %b/%h/%b exp 1/014/1", if_gnt, ram_addr, if_stall); end
      @(negedge clk); #1;
      vec_cnt++; if (if_rvalid !== 1'b0) begin err_cnt++; $display("[TB] FAIL flush_t3_rvalid got %b exp 0", if_rvalid); end
      @(negedge clk); if_req = 1'b0; #1;
      vec_cnt++; if ({if_rvalid, if_rdata} !== {1'b1, 32'hC0DE_0014}) begin err_cnt++; $display("[TB] FAIL flush_t4 rvalid/rdata got %b/%h exp 1/c0de0014", if_rvalid, if_rdata); end
      // Flush in an idle grant cycle blocks IF; MEM gets the port instead.
      @(negedge clk); if_req = 1'b1; if_flush = 1'b1; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; #1;
      vec_cnt++; if ({if_gnt, mem_gnt, ram_addr} !== {1'b0, 1'b1, 10'h040}) begin err_cnt++; $display("[TB] FAIL flush_block igrant/mgrant/addr got %b/%b/%h exp 0/1/040", if_gnt, mem_gnt, ram_addr); end
      @(negedge clk); if_req = 1'b0; if_flush = 1'b0; #1;
      @(negedge clk); mem_req = 1'b0; #1;
      vec_cnt++; if ({mem_rvalid, mem_rdata, if_rvalid} !== {1'b1, 32'hC0DE_0040, 1'b0}) begin err_cnt++; $display("[TB] FAIL flush_mem_done got %b/%h/%b exp 1/c0de0040/0", mem_rvalid, mem_rdata, if_rvalid); end
   endtask

   task automatic test_store;
      @(negedge clk); mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8; mem_wdata = 32'hDEAD_BEEF; #1;
      vec_cnt++; if ({mem_gnt, ram_en, ram_we} !== 3'b111) begin err_cnt++; $display("[TB] FAIL store_t0 gnt/en/we got %b exp 111", {mem_gnt, ram_en, ram_we}); end
      vec_cnt++; if ({ram_addr, ram_wdata} !== {10'h002, 32'hDEAD_BEEF}) begin err_cnt++; $display("[TB] FAIL store_t0 addr/wdata got %h/%h exp 002/deadbeef", ram_addr, ram_wdata); end
      @(negedge clk); #1;
      // Fetch with upper and lower byte-address bits set: they must be ignored.
      @(negedge clk); mem_req = 1'b0; mem_we = 1'b0; if_req = 1'b1; if_addr = 32'h8000_100B; #1;
      vec_cnt++; if ({mem_rvalid, mem_rdata} !== {1'b1, 32'h0}) begin err_cnt++; $display("[TB] FAIL store_ack rvalid/rdata got %b/%h exp 1/0", mem_rvalid, mem_rdata); end
      vec_cnt++; if ({if_gnt, ram_we, ram_addr} !== {1'b1, 1'b0, 10'h002}) begin err_cnt++; $display("[TB] FAIL store_fetch gnt/we/addr got %b/%b/%h exp 1/0/002", if_gnt, ram_we, ram_addr); end
      @(negedge clk); #1;
      @(negedge clk); if_req = 1'b0; #1;
      vec_cnt++; if ({if_rvalid, if_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin err_cnt++; $display("[TB] FAIL store_readback got %b/%h exp 1/deadbeef", if_rvalid, if_rdata); end
   endtask

   task automatic test_reset_mid;
      @(negedge clk); if_req = 1'b1; if_addr = 32'h40; #1;
      vec_cnt++; if (if_gnt !== 1'b1) begin err_cnt++; $display("[TB] FAIL rstmid_t0_gnt got %b exp 1", if_gnt); end
      @(negedge clk); rst = 1'b1; #1;
      vec_cnt++; if (all_out !== '0) begin err_cnt++; $display("[TB] FAIL rstmid_t1 outputs got %h exp 0", all_out); end
      @(negedge clk); rst = 1'b0; #1;
      vec_cnt++; if (if_rvalid !== 1'b0) begin err_cnt++; $display("[TB] FAIL rstmid_t2_rvalid got %b exp 0", if_rvalid); end
      vec_cnt++; if ({if_gnt, ram_addr} !== {1'b1, 10'h010}) begin err_cnt++; $display("[TB] FAIL rstmid_t2 gnt/addr got %b/%h exp 1/010", if_gnt, ram_addr); end
      @(negedge clk); #1;
      @(negedge clk); if_req = 1'b0; #1;
      vec_cnt++; if ({if_rvalid, if_rdata} !== {1'b1, 32'hC0DE_0010}) begin err_cnt++; $display("[TB] FAIL rstmid_t4 rvalid/rdata got %b/%h exp 1/c0de0010", if_rvalid, if_rdata); end
   endtask

   initial begin
      rst       = 1'b1;
      if_req    = 1'b0;
      if_addr   = 32'h0;
      if_flush  = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;

      $display("[TB] starting mem_port_arbiter directed tests");
      test_reset;
      test_back_to_back;
      test_contention;
      test_streak;
      test_flush;
      test_store;
      test_reset_mid;

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
